// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_src_e;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_GNT  = 2'b01,
    WAIT_RESP = 2'b10
  } lsu_state_e;

  // Unsupported encodings (including sign-variant stores) count as misaligned
  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] a,
                                          input logic is_load);
    logic r;
    case (f3)
      F3_B:    r = 1'b0;
      F3_H:    r = a[0];
      F3_W:    r = |a;
      F3_BU:   r = ~is_load;
      F3_HU:   r = ~is_load | a[0];
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts and extends the addressed byte/halfword/word from a load response.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection and sign/zero extension
  always_comb begin
    byte_s = rdata[{addr, 3'b000} +: 8];
    half_s = addr[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_s[7]}}, byte_s};
      F3_BU:   data = {24'h000000, byte_s};
      F3_H:    data = {{16{half_s[15]}}, half_s};
      F3_HU:   data = {16'h0000, half_s};
      F3_W:    data = rdata;
      default: data = 32'h00000000;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage: issues data-memory requests over req/gnt/rvalid and drives the MEM/WB register.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int RESP_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            validM,
  input  logic            regWriteM,
  input  logic [4:0]      rdM,
  input  logic            memReadM,
  input  logic            memWriteM,
  input  logic [2:0]      funct3M,
  input  logic [1:0]      resultSrcM,
  input  logic [XLEN-1:0] aluResultM,
  input  logic [XLEN-1:0] writeDataM,
  input  logic [XLEN-1:0] pcPlus4M,
  output logic            dmemReq,
  output logic            dmemWe,
  output logic [XLEN-1:0] dmemAddr,
  output logic [3:0]      dmemBe,
  output logic [XLEN-1:0] dmemWdata,
  input  logic            dmemGnt,
  input  logic            dmemRvalid,
  input  logic [XLEN-1:0] dmemRdata,
  output logic            stallM,
  output logic            misalignM,
  output logic            busErrM,
  output logic            validW,
  output logic            regWriteW,
  output logic [4:0]      rdW,
  output logic [XLEN-1:0] resultW
);

  localparam int CW = (RESP_TIMEOUT < 2) ? 1 : $clog2(RESP_TIMEOUT + 1);

  lsu_state_e      state_r, state_nx_s;
  logic [CW-1:0]   cnt_r;
  logic            is_load_s, mem_op_s, misal_s, issue_s, timeout_s;
  logic            w_valid_s, w_regwrite_s, misal_pulse_s, berr_pulse_s;
  logic [XLEN-1:0] w_result_s, load_data_s, src_result_s;
  logic            validw_r, regwritew_r, misal_r, berr_r;
  logic [4:0]      rdw_r;
  logic [XLEN-1:0] resultw_r;

  load_align u_load_align (
    .rdata  (dmemRdata),
    .addr   (aluResultM[1:0]),
    .funct3 (funct3M),
    .data   (load_data_s)
  );

  assign is_load_s = memReadM;
  assign mem_op_s  = validM & (memReadM | memWriteM);
  assign misal_s   = mem_op_s & lsu_misaligned(funct3M, aluResultM[1:0], is_load_s);
  assign issue_s   = mem_op_s & ~misal_s & ((state_r == IDLE) | (state_r == WAIT_GNT));
  assign timeout_s = (RESP_TIMEOUT != 0) && (cnt_r == CW'(RESP_TIMEOUT - 1));

  // Writeback value selection
  always_comb begin
    case (res_src_e'(resultSrcM))
      RES_ALU: src_result_s = aluResultM;
      RES_MEM: src_result_s = load_data_s;
      RES_PC4: src_result_s = pcPlus4M;
      default: src_result_s = '0;
    endcase
  end

  // Next-state, stall and retirement decision
  always_comb begin
    state_nx_s    = state_r;
    stallM        = 1'b0;
    w_valid_s     = 1'b0;
    w_regwrite_s  = 1'b0;
    w_result_s    = '0;
    misal_pulse_s = 1'b0;
    berr_pulse_s  = 1'b0;
    if (issue_s) begin
      if (!dmemGnt) begin
        state_nx_s = WAIT_GNT;
        stallM     = 1'b1;
      end else if (is_load_s) begin
        state_nx_s = WAIT_RESP;
        stallM     = 1'b1;
      end else begin
        state_nx_s = IDLE;
        w_valid_s  = 1'b1;
      end
    end else begin
      case (state_r)
        WAIT_RESP: begin
          if (dmemRvalid) begin
            state_nx_s   = IDLE;
            w_valid_s    = 1'b1;
            w_regwrite_s = regWriteM;
            w_result_s   = src_result_s;
          end else if (timeout_s) begin
            state_nx_s   = IDLE;
            w_valid_s    = 1'b1;
            berr_pulse_s = 1'b1;
          end else begin
            stallM = 1'b1;
          end
        end
        default: begin
          state_nx_s = IDLE;
          if (misal_s) begin
            w_valid_s     = 1'b1;
            misal_pulse_s = 1'b1;
          end else if (validM && !mem_op_s) begin
            w_valid_s    = 1'b1;
            w_regwrite_s = regWriteM;
            w_result_s   = src_result_s;
          end else begin
            w_valid_s = 1'b0;
          end
        end
      endcase
    end
  end

  // Request bus, zeroed whenever no request is presented
  always_comb begin
    dmemReq   = issue_s;
    dmemWe    = issue_s & ~is_load_s;
    dmemAddr  = '0;
    dmemBe    = 4'b0000;
    dmemWdata = '0;
    if (issue_s) begin
      dmemAddr = {aluResultM[XLEN-1:2], 2'b00};
      case (funct3M)
        F3_B: begin
          dmemBe    = 4'b0001 << aluResultM[1:0];
          dmemWdata = {4{writeDataM[7:0]}};
        end
        F3_H: begin
          dmemBe    = 4'b0011 << aluResultM[1:0];
          dmemWdata = {2{writeDataM[15:0]}};
        end
        default: begin
          dmemBe    = 4'b1111;
          dmemWdata = writeDataM;
        end
      endcase
    end else begin
      dmemWe = 1'b0;
    end
  end

  // State, response timer and MEM/WB register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      validw_r    <= 1'b0;
      regwritew_r <= 1'b0;
      rdw_r       <= 5'd0;
      resultw_r   <= '0;
      misal_r     <= 1'b0;
      berr_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      cnt_r       <= (state_r == WAIT_RESP && state_nx_s == WAIT_RESP) ? cnt_r + CW'(1) : '0;
      validw_r    <= w_valid_s;
      regwritew_r <= w_valid_s & w_regwrite_s;
      rdw_r       <= w_valid_s ? rdM : 5'd0;
      resultw_r   <= w_result_s;
      misal_r     <= misal_pulse_s;
      berr_r      <= berr_pulse_s;
    end
  end

  assign validW    = validw_r;
  assign regWriteW = regwritew_r;
  assign rdW       = rdw_r;
  assign resultW   = resultw_r;
  assign misalignM = misal_r;
  assign busErrM   = berr_r;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a short response timeout.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        validM, regWriteM, memReadM, memWriteM;
  logic [4:0]  rdM;
  logic [2:0]  funct3M;
  logic [1:0]  resultSrcM;
  logic [31:0] aluResultM, writeDataM, pcPlus4M;
  logic        dmemReq, dmemWe, dmemGnt, dmemRvalid;
  logic [31:0] dmemAddr, dmemWdata, dmemRdata;
  logic [3:0]  dmemBe;
  logic        stallM, misalignM, busErrM, validW, regWriteW;
  logic [4:0]  rdW;
  logic [31:0] resultW;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.XLEN(32), .RESP_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .validM(validM), .regWriteM(regWriteM), .rdM(rdM),
    .memReadM(memReadM), .memWriteM(memWriteM), .funct3M(funct3M), .resultSrcM(resultSrcM),
    .aluResultM(aluResultM), .writeDataM(writeDataM), .pcPlus4M(pcPlus4M),
    .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr), .dmemBe(dmemBe),
    .dmemWdata(dmemWdata), .dmemGnt(dmemGnt), .dmemRvalid(dmemRvalid), .dmemRdata(dmemRdata),
    .stallM(stallM), .misalignM(misalignM), .busErrM(busErrM), .validW(validW),
    .regWriteW(regWriteW), .rdW(rdW), .resultW(resultW)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in();
    validM = 1'b0; regWriteM = 1'b0; rdM = 5'd0; memReadM = 1'b0; memWriteM = 1'b0;
    funct3M = 3'b000; resultSrcM = 2'b00; aluResultM = 32'h0; writeDataM = 32'h0;
    pcPlus4M = 32'h0; dmemGnt = 1'b0; dmemRvalid = 1'b0; dmemRdata = 32'h0;
  endtask

  task automatic load_op(input logic [2:0] f3, input logic [31:0] addr);
    validM = 1'b1; memReadM = 1'b1; regWriteM = 1'b1; rdM = 5'd9;
    resultSrcM = 2'b01; funct3M = f3; aluResultM = addr;
  endtask

  // Granted load answered one cycle after the grant
  task automatic load_test(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
    load_op(f3, addr);
    dmemGnt = 1'b1;
    #1 chk({tag, "_req"}, {31'd0, dmemReq}, 32'd1);
    tick();
    dmemGnt = 1'b0; dmemRvalid = 1'b1; dmemRdata = rdata;
    #1 chk({tag, "_stall"}, {31'd0, stallM}, 32'd0);
    tick();
    idle_in();
    #1 chk({tag, "_res"}, resultW, exp);
    chk({tag, "_rw"}, {31'd0, regWriteW}, 32'd1);
  endtask

  initial begin
    idle_in();
    rst_n = 1'b0;
    #12;
    chk("rst_validW", {31'd0, validW}, 32'd0);
    chk("rst_resultW", resultW, 32'd0);
    chk("rst_rdW", {27'd0, rdW}, 32'd0);
    chk("rst_pulses", {30'd0, misalignM, busErrM}, 32'd0);
    chk("rst_comb", {30'd0, dmemReq, stallM}, 32'd0);
    rst_n = 1'b1;
    tick();

    // ALU op, PC+4 select and the unused select encoding
    validM = 1'b1; regWriteM = 1'b1; rdM = 5'd5; aluResultM = 32'h1234; pcPlus4M = 32'h88;
    #1 chk("alu_stall", {30'd0, stallM, dmemReq}, 32'd0);
    tick();
    resultSrcM = 2'b10;
    #1 chk("alu_valid", {30'd0, validW, regWriteW}, 32'd3);
    chk("alu_rd", {27'd0, rdW}, 32'd5);
    chk("alu_res", resultW, 32'h1234);
    tick();
    resultSrcM = 2'b11;
    #1 chk("pc4_res", resultW, 32'h88);
    tick();
    idle_in();
    #1 chk("src11_res", resultW, 32'h0);
    tick();
    chk("bubble_valid", {31'd0, validW}, 32'd0);

    // LB at 0x1003: grant in cycle 0, rvalid in cycle 2
    load_op(3'b000, 32'h1003);
    rdM = 5'd7; dmemGnt = 1'b1;
    #1 chk("lb_c0", {30'd0, dmemReq, stallM}, 32'd3);
    chk("lb_addr", dmemAddr, 32'h1000);
    chk("lb_we", {31'd0, dmemWe}, 32'd0);
    tick();
    dmemGnt = 1'b0;
    #1 chk("lb_c1", {30'd0, dmemReq, stallM}, 32'd1);
    chk("lb_c1_bubble", {31'd0, validW}, 32'd0);
    tick();
    dmemRvalid = 1'b1; dmemRdata = 32'h80FF_FF00;
    #1 chk("lb_c2_stall", {31'd0, stallM}, 32'd0);
    tick();
    idle_in();
    #1 chk("lb_res", resultW, 32'hFFFF_FF80);
    chk("lb_rd", {27'd0, rdW}, 32'd7);

    load_test("lh", 3'b001, 32'h1002, 32'h80FF_FF00, 32'hFFFF_80FF);
    load_test("lhu", 3'b101, 32'h1002, 32'h80FF_FF00, 32'h0000_80FF);
    load_test("lbu", 3'b100, 32'h1001, 32'h80FF_FF00, 32'h0000_00FF);
    load_test("lw", 3'b010, 32'h1000, 32'h80FF_FF00, 32'h80FF_FF00);

    // SH at 0x2002 with grant withheld for three cycles
    validM = 1'b1; memWriteM = 1'b1; funct3M = 3'b001; aluResultM = 32'h2002;
    writeDataM = 32'h0000_ABCD;
    for (int c = 0; c < 3; c++) begin
      #1 chk("sh_wait", {30'd0, dmemReq, stallM}, 32'd3);
      chk("sh_be", {28'd0, dmemBe}, 32'hC);
      chk("sh_wdata", dmemWdata, 32'hABCD_ABCD);
      tick();
    end
    dmemGnt = 1'b1;
    #1 chk("sh_gnt", {30'd0, dmemReq, stallM}, 32'd2);
    chk("sh_addr_we", {dmemAddr[31:1], dmemWe}, 32'h2001);
    tick();
    idle_in();
    #1 chk("sh_retire", {30'd0, validW, regWriteW}, 32'd2);

    // SB at lane 1 with immediate grant
    validM = 1'b1; memWriteM = 1'b1; funct3M = 3'b000; aluResultM = 32'h3001;
    writeDataM = 32'h1234_565A; dmemGnt = 1'b1;
    #1 chk("sb_be", {28'd0, dmemBe}, 32'h2);
    chk("sb_wdata", dmemWdata, 32'h5A5A_5A5A);
    chk("sb_stall", {31'd0, stallM}, 32'd0);
    tick();
    idle_in();

    // LW at 0x0006 is misaligned
    load_op(3'b010, 32'h0006);
    #1 chk("mis_noreq", {30'd0, dmemReq, stallM}, 32'd0);
    tick();
    idle_in();
    #1 chk("mis_pulse", {31'd0, misalignM}, 32'd1);
    chk("mis_retire", {30'd0, validW, regWriteW}, 32'd2);
    tick();
    chk("mis_pulse_end", {31'd0, misalignM}, 32'd0);

    // Response timeout after four WAIT_RESP cycles
    load_op(3'b010, 32'h0100);
    dmemGnt = 1'b1;
    tick();
    dmemGnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk("to_stall", {31'd0, stallM}, 32'd1);
      chk("to_no_err", {31'd0, busErrM}, 32'd0);
      tick();
    end
    #1 chk("to_4th_stall", {31'd0, stallM}, 32'd0);
    tick();
    idle_in();
    #1 chk("to_berr", {31'd0, busErrM}, 32'd1);
    chk("to_retire", {30'd0, validW, regWriteW}, 32'd2);
    tick();
    chk("to_berr_end", {31'd0, busErrM}, 32'd0);

    // Reset while waiting for a response, stale rvalid afterwards
    load_op(3'b010, 32'h0200);
    dmemGnt = 1'b1;
    tick();
    idle_in();
    rst_n = 1'b0;
    #1 chk("rst_mid_out", {28'd0, validW, regWriteW, stallM, dmemReq}, 32'd0);
    chk("rst_mid_res", resultW, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    dmemRvalid = 1'b1; dmemRdata = 32'hDEAD_BEEF;
    #1 chk("stale_stall", {31'd0, stallM}, 32'd0);
    tick();
    dmemRvalid = 1'b0;
    #1 chk("stale_valid", {31'd0, validW}, 32'd0);
    chk("stale_res", resultW, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
MEM stage of the 5-stage pipeline: takes the EX/MEM register contents, performs loads and stores against the data memory over a req/gnt/rvalid handshake, and drives the MEM/WB register.
- Its registered outputs (regWriteW, rdW, resultW) are the MEM/WB-side inputs consumed by EX-stage forwarding.
- stallM freezes all upstream pipeline registers while a memory access is outstanding.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
RESP_TIMEOUT, 255, cycles in WAIT_RESP before busErrM is raised; 0 disables the timeout.

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
validM  in  1  EX/MEM holds a real instruction
regWriteM  in  1  instruction writes rd
rdM  in  5  destination register
memReadM  in  1  load
memWriteM  in  1  store
funct3M  in  3  access size/sign (RISC-V encoding)
resultSrcM  in  2  00 ALU, 01 load data, 10 PC+4
aluResultM  in  XLEN  ALU result / effective address
writeDataM  in  XLEN  store data (rs2)
pcPlus4M  in  XLEN  link value
dmemReq  out  1  access request
dmemWe  out  1  1 = store
dmemAddr  out  XLEN  word-aligned address ({aluResultM[31:2],2'b00})
dmemBe  out  4  byte enables
dmemWdata  out  XLEN  lane-replicated store data
dmemGnt  in  1  request accepted this cycle
dmemRvalid  in  1  load data valid
dmemRdata  in  XLEN  load word
stallM  out  1  M instruction cannot retire this cycle
misalignM  out  1  one-cycle pulse: misaligned access dropped
busErrM  out  1  one-cycle pulse: response timeout
validW  out  1  MEM/WB valid
regWriteW  out  1  MEM/WB write enable (0 whenever validW=0)
rdW  out  5  MEM/WB destination
resultW  out  XLEN  MEM/WB writeback value

Behaviour:
- Reset:
  - Async assert clears all state to IDLE.
  - validW, regWriteW, rdW, resultW, misalignM and busErrM all clear to 0.
  - Combinational outputs settle to 0 because no instruction is held.
  - Reset mid-access abandons the transaction; a later dmemRvalid is ignored.
- FSM states: IDLE, WAIT_GNT, WAIT_RESP.
- Non-memory instruction (validM, !memReadM, !memWriteM):
  - stallM=0; the W registers load on the next edge (latency 1).
  - resultW is selected by resultSrcM; resultSrcM=11 yields 0.
- Memory operation in IDLE, aligned:
  - dmemReq=1 combinationally, same cycle.
  - Store with dmemGnt=1: retires on that edge, stallM=0, no response is expected.
  - Store without grant: go to WAIT_GNT.
  - Load with grant: go to WAIT_RESP, stallM=1.
  - Load without grant: go to WAIT_GNT.
- WAIT_GNT:
  - dmemReq stays 1; address, byte enables and data are held stable because upstream is stalled.
  - On grant, apply the same rules as the IDLE grant case.
  - stallM=1 except in the store-grant cycle.
- WAIT_RESP:
  - dmemReq=0, stallM=1.
  - dmemRvalid=1: the load retires that edge with the extracted value, state returns to IDLE, stallM=0 that cycle.
  - Protocol: rvalid never arrives in the same cycle as its gnt. rvalid in IDLE or WAIT_GNT is ignored.
- Timeout: a counter (8 bits at the default RESP_TIMEOUT) runs in WAIT_RESP. On reaching RESP_TIMEOUT:
  - busErrM pulses and the instruction retires with regWriteW=0.
  - State returns to IDLE.
- Misalignment (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0):
  - No request is issued and misalignM pulses.
  - The instruction retires next edge as a bubble: validW=1, regWriteW=0.
- Load extraction, using lane = addr[1:0]:
  - LB/LBU: select that byte; LH/LHU: select the halfword at addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - funct3 values 011, 110 and 111 are treated as misaligned.
- Store lanes:
  - SB: be=0001<<lane, data = byte replicated ×4.
  - SH: be=0011<<lane, data = halfword replicated ×2.
  - SW: be=1111.
- rdW=0 is passed through; suppressing writes to x0 is downstream's job.
- While stallM=1 the W registers load a bubble each cycle (validW=0, regWriteW=0).
- validM=0: W outputs load a bubble; no request is issued.

Decomposition:
- lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the resultSrc enum (RES_ALU, RES_MEM, RES_PC4);
  - the lsu_state_e typedef.
- Sub-module load_align, purely combinational: inputs rdata, addr[1:0], funct3; output extended word. It is unit-testable in isolation.

Test Plan:
- ALU op with regWriteM=1, rdM=5, aluResultM=0x1234, resultSrcM=00 → next cycle validW=1, regWriteW=1, rdW=5, resultW=0x1234; stallM never asserted.
- LB at 0x1003; gnt in cycle 0, rdata=0x80FF_FF00 in cycle 2 → stallM high for cycles 0–1, low in cycle 2; resultW=0xFFFF_FF80.
- SH at 0x2002, data 0xABCD, gnt held low 3 cycles → dmemReq stays high, be=1100, wdata=0xABCD_ABCD; retires on the 4th cycle with regWriteW=0.
- LW at 0x0006 → no dmemReq, misalignM pulses 1 cycle, validW=1, regWriteW=0.
- Load granted, no rvalid for RESP_TIMEOUT=4 → busErrM pulses at the 4th WAIT_RESP cycle, stallM drops, FSM returns to IDLE.
- rst_n asserted in WAIT_RESP, then rvalid after release → all outputs are 0 and the stale rvalid is ignored (validW stays 0).
